rob_walk_ctrl: RTL and testbench
================================

ROB_WALK_CTRL -- requirements
Module: rob_walk_ctrl

Interface
REQ-001 Parameter ROB_DEPTH, default 64: ROB entries; power of two.
REQ-002 Parameter PREG_WIDTH, default 6: physical register index width.
REQ-003 Derived ROB_AW = log2(ROB_DEPTH); a pointer is ROB_AW+1 bits, with the MSB as the wrap bit.
REQ-004 clock  in  1  clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 flush_valid  in  1  redirect request from commit/branch unit.
REQ-007 flush_robidx  in  ROB_AW+1  pointer of the flushing instruction; that instruction is kept, and all younger entries are squashed.
REQ-008 rob_tail_ptr  in  ROB_AW+1  current ROB enqueue pointer; one past the youngest entry.
REQ-009 walk_rd_idx0 / walk_rd_idx1  out  ROB_AW  ROB read addresses for the two walk lanes.
REQ-010 walk_rd_need_to_wb0/1  in  1  the addressed entry allocated a prd; data is combinational, valid in the same cycle.
REQ-011 walk_rd_prd0/1  in  PREG_WIDTH  prd allocated by the addressed entry.
REQ-012 rob_state  out  2  recovery state; drives the freelist and rename table.
REQ-013 walking_valid0/1  out  1  lane returns a prd to the freelist this cycle.
REQ-014 walking_old_prd0/1  out  PREG_WIDTH  prd being returned.
REQ-015 rename_stall  out  1  high whenever rob_state != IDLE.
REQ-016 walk_done  out  1  one-cycle pulse when recovery completes.

Function
REQ-017 The block SHALL implement the states IDLE=2'b00, ROLLBACK=2'b01 and WALK=2'b10; 2'b11 is illegal and SHALL recover to IDLE on the next cycle.
REQ-018 IDLE with flush_valid: SHALL register walk_ptr = flush_robidx+1 and end_ptr = rob_tail_ptr, and SHALL enter ROLLBACK next cycle.
REQ-019 ROLLBACK SHALL last exactly one cycle; next state is WALK if walk_ptr != end_ptr, else IDLE with walk_done asserted in that IDLE cycle.
REQ-020 remaining = (end_ptr - walk_ptr) mod 2^(ROB_AW+1); walk_rd_idx0 = walk_ptr[ROB_AW-1:0], walk_rd_idx1 = (walk_ptr+1)[ROB_AW-1:0], wrapping at ROB_DEPTH.
REQ-021 In WALK, lane k is in range iff k < remaining; walking_valid_k SHALL equal (in range && walk_rd_need_to_wb_k), and walking_old_prd_k SHALL equal walk_rd_prd_k, combinationally in the same cycle.
REQ-022 In WALK, walk_ptr SHALL advance by min(remaining, 2) per cycle, independent of need_to_wb.
REQ-023 When remaining <= 2 in WALK, the next state SHALL be IDLE and walk_done SHALL pulse in that next cycle.
REQ-024 Outside WALK, walking_valid0/1 SHALL be 0 and walking_old_prd0/1 SHALL be 0.
REQ-025 flush_valid in ROLLBACK or WALK: if flush_robidx is older than the current walk_ptr-1 (wrap-aware compare), the block SHALL reload walk_ptr and end_ptr and re-enter ROLLBACK; otherwise the flush SHALL be ignored.
REQ-026 A newly captured end_ptr SHALL be held until the walk completes; later changes on rob_tail_ptr SHALL be ignored.
REQ-027 A full-ROB walk (remaining = ROB_DEPTH) SHALL complete in ROB_DEPTH/2 WALK cycles.

Reset
REQ-028 On reset_n low, the block SHALL immediately force state=IDLE, walk_ptr=0, end_ptr=0, and all outputs to 0, including walk_done.
REQ-029 Reset asserted mid-WALK SHALL abandon the walk; no walking_valid SHALL be asserted after reset deassertion until a new flush.

Structure
REQ-030 The ROB_STATE_IDLE/ROLLBACK/WALK encodings and the pointer-width constants SHALL reside in the shared backend package, which the freelist also uses.
REQ-031 The wrap-aware age compare SHALL be a sub-module rob_ptr_older (two pointers in, one "a older than b" bit out); no other sub-modules.

Verification
REQ-032 ROB_DEPTH=64; flush_robidx=5, tail=9, all need_to_wb=1, prds 40..42 -> ROLLBACK 1 cycle; WALK cycle 1 returns 40,41; WALK cycle 2 returns lane0 42 only; walk_done in the following cycle.
REQ-033 flush_robidx=9, tail=10 -> ROLLBACK, then IDLE with walk_done; no walking_valid asserted.
REQ-034 Wrap case: flush_robidx=7'd62, tail=7'd67 -> read indices 63,0 then 1,2; 4 entries walked over 2 cycles.
REQ-035 need_to_wb pattern 1,0,1,0 over 4 entries -> walking_valid pairs (1,0),(1,0); walk_ptr still advances by 2 per cycle.
REQ-036 Mid-WALK flush with an older index (3, during a walk from 10) -> ROLLBACK, restart at 4; a flush with a younger index (20) -> ignored.
REQ-037 reset_n low during WALK -> outputs 0 immediately; after release, state stays IDLE with no walking_valid.

Source files
------------

// File: rtl/rob_walk_ctrl_pkg.sv
// Shared backend package: ROB recovery state encodings and default ROB
// pointer geometry. The freelist and rename table import the same state
// type so that they decode rob_state identically.
package rob_walk_ctrl_pkg;

  localparam int ROB_DEPTH_DEF  = 64;
  localparam int PREG_WIDTH_DEF = 6;
  localparam int ROB_AW_DEF     = $clog2(ROB_DEPTH_DEF);
  // Pointers carry one extra MSB as the wrap bit.
  localparam int ROB_PTR_W_DEF  = ROB_AW_DEF + 1;

  // Number of ROB entries the walk can retire per cycle.
  localparam int WALK_LANES = 2;

  typedef enum logic [1:0] {
    ROB_STATE_IDLE     = 2'b00,
    ROB_STATE_ROLLBACK = 2'b01,
    ROB_STATE_WALK     = 2'b10
  } rob_state_e;

endpackage

// File: rtl/rob_walk_ctrl_ptr_older.sv
// rob_ptr_older: wrap-aware age compare of two ROB pointers.
//   ptr_a, ptr_b : PTR_W-bit pointers, MSB is the wrap bit
//   a_older      : 1 when ptr_a refers to an older entry than ptr_b
// With equal wrap bits the smaller index is older; with differing wrap bits
// the pointer that has not yet wrapped holds the larger index and is older.
module rob_ptr_older #(
  parameter int PTR_W = 7
) (
  input  logic [PTR_W-1:0] ptr_a,
  input  logic [PTR_W-1:0] ptr_b,
  output logic             a_older
);

  logic same_wrap;

  assign same_wrap = (ptr_a[PTR_W-1] == ptr_b[PTR_W-1]);
  assign a_older   = same_wrap ? (ptr_a[PTR_W-2:0] < ptr_b[PTR_W-2:0])
                               : (ptr_a[PTR_W-2:0] > ptr_b[PTR_W-2:0]);

endmodule

// File: rtl/rob_walk_ctrl.sv
// rob_walk_ctrl: ROB recovery walk controller.
// On a redirect the block spends one ROLLBACK cycle, then walks the squashed
// ROB entries two per cycle, returning each allocated prd to the freelist.
// Ports:
//   clock, reset_n                 : clock, asynchronous active-low reset
//   flush_valid, flush_robidx      : redirect; the flushing entry is kept
//   rob_tail_ptr                   : ROB enqueue pointer (one past youngest)
//   walk_rd_idx0/1                 : ROB read addresses for the two lanes
//   walk_rd_need_to_wb0/1, _prd0/1 : combinational ROB read data
//   rob_state                      : IDLE / ROLLBACK / WALK
//   walking_valid0/1, old_prd0/1   : prds returned to the freelist
//   rename_stall                   : rename held while recovering
//   walk_done                      : one-cycle pulse when recovery ends
module rob_walk_ctrl
  import rob_walk_ctrl_pkg::*;
#(
  parameter int ROB_DEPTH  = ROB_DEPTH_DEF,
  parameter int PREG_WIDTH = PREG_WIDTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush_valid,
  input  logic [$clog2(ROB_DEPTH):0]   flush_robidx,
  input  logic [$clog2(ROB_DEPTH):0]   rob_tail_ptr,
  output logic [$clog2(ROB_DEPTH)-1:0] walk_rd_idx0,
  output logic [$clog2(ROB_DEPTH)-1:0] walk_rd_idx1,
  input  logic                         walk_rd_need_to_wb0,
  input  logic                         walk_rd_need_to_wb1,
  input  logic [PREG_WIDTH-1:0]        walk_rd_prd0,
  input  logic [PREG_WIDTH-1:0]        walk_rd_prd1,
  output logic [1:0]                   rob_state,
  output logic                         walking_valid0,
  output logic                         walking_valid1,
  output logic [PREG_WIDTH-1:0]        walking_old_prd0,
  output logic [PREG_WIDTH-1:0]        walking_old_prd1,
  output logic                         rename_stall,
  output logic                         walk_done
);

  localparam int AW = $clog2(ROB_DEPTH);
  localparam int PW = AW + 1;

  rob_state_e     state_reg, state_next;
  logic [PW-1:0]  walk_ptr_reg, walk_ptr_next;
  logic [PW-1:0]  end_ptr_reg, end_ptr_next;
  logic           walk_done_reg, walk_done_next;

  logic [PW-1:0]  remaining;
  logic [PW-1:0]  walk_step;
  logic [PW-1:0]  walk_ptr_m1;
  logic           flush_is_older;
  logic           in_walk;

  logic [AW-1:0]         lane_idx     [WALK_LANES];
  logic                  lane_need    [WALK_LANES];
  logic [PREG_WIDTH-1:0] lane_prd     [WALK_LANES];
  logic                  lane_valid   [WALK_LANES];
  logic [PREG_WIDTH-1:0] lane_old_prd [WALK_LANES];

  // Entries still to be walked; modulo arithmetic on full pointers lets a
  // full ROB (ROB_DEPTH entries) be distinguished from an empty walk.
  assign remaining   = end_ptr_reg - walk_ptr_reg;
  assign walk_step   = (remaining >= PW'(2)) ? PW'(2) : remaining;
  assign walk_ptr_m1 = walk_ptr_reg - PW'(1);
  assign in_walk     = (state_reg == ROB_STATE_WALK);

  // A re-flush only matters if it squashes entries already kept by the
  // current recovery, i.e. it is older than the current flush point.
  rob_ptr_older #(
    .PTR_W (PW)
  ) u_flush_older (
    .ptr_a   (flush_robidx),
    .ptr_b   (walk_ptr_m1),
    .a_older (flush_is_older)
  );

  assign lane_need[0] = walk_rd_need_to_wb0;
  assign lane_need[1] = walk_rd_need_to_wb1;
  assign lane_prd[0]  = walk_rd_prd0;
  assign lane_prd[1]  = walk_rd_prd1;

  generate
    for (genvar gi = 0; gi < WALK_LANES; gi++) begin : g_lane
      logic in_range;
      // Low-bit add wraps at ROB_DEPTH on its own.
      assign lane_idx[gi]     = walk_ptr_reg[AW-1:0] + AW'(gi);
      assign in_range         = (remaining > PW'(gi));
      assign lane_valid[gi]   = in_walk && in_range && lane_need[gi];
      assign lane_old_prd[gi] = in_walk ? lane_prd[gi] : '0;
    end
  endgenerate

  // Read addresses are only meaningful while walking; hold them at zero
  // otherwise so the block presents all-zero outputs out of reset.
  assign walk_rd_idx0     = in_walk ? lane_idx[0] : '0;
  assign walk_rd_idx1     = in_walk ? lane_idx[1] : '0;
  assign walking_valid0   = lane_valid[0];
  assign walking_valid1   = lane_valid[1];
  assign walking_old_prd0 = lane_old_prd[0];
  assign walking_old_prd1 = lane_old_prd[1];
  assign rob_state        = state_reg;
  assign rename_stall     = (state_reg != ROB_STATE_IDLE);
  assign walk_done        = walk_done_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ROB_STATE_IDLE;
      walk_ptr_reg  <= '0;
      end_ptr_reg   <= '0;
      walk_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      walk_ptr_reg  <= walk_ptr_next;
      end_ptr_reg   <= end_ptr_next;
      walk_done_reg <= walk_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    walk_ptr_next  = walk_ptr_reg;
    end_ptr_next   = end_ptr_reg;
    walk_done_next = 1'b0;

    case (state_reg)
      ROB_STATE_IDLE: begin
        if (flush_valid) begin
          walk_ptr_next = flush_robidx + PW'(1);
          end_ptr_next  = rob_tail_ptr;
          state_next    = ROB_STATE_ROLLBACK;
        end
      end

      ROB_STATE_ROLLBACK: begin
        if (flush_valid && flush_is_older) begin
          walk_ptr_next = flush_robidx + PW'(1);
          end_ptr_next  = rob_tail_ptr;
          state_next    = ROB_STATE_ROLLBACK;
        end else if (remaining != '0) begin
          state_next = ROB_STATE_WALK;
        end else begin
          state_next     = ROB_STATE_IDLE;
          walk_done_next = 1'b1;
        end
      end

      ROB_STATE_WALK: begin
        if (flush_valid && flush_is_older) begin
          walk_ptr_next = flush_robidx + PW'(1);
          end_ptr_next  = rob_tail_ptr;
          state_next    = ROB_STATE_ROLLBACK;
        end else begin
          walk_ptr_next = walk_ptr_reg + walk_step;
          if (remaining <= PW'(2)) begin
            state_next     = ROB_STATE_IDLE;
            walk_done_next = 1'b1;
          end
        end
      end

      // Unused encoding: fall back to IDLE without signalling completion.
      default: begin
        state_next = ROB_STATE_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rob_walk_ctrl.sv
// Scoreboard bench for rob_walk_ctrl (ROB_DEPTH=64, PREG_WIDTH=6).
// A small ROB array answers the walk read ports combinationally. Each cycle
// the stimulus pushes the outputs it expects for that cycle; a checker pops
// and compares them on the falling edge.
module tb_rob_walk_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       flush_valid;
  logic [6:0] flush_robidx;
  logic [6:0] rob_tail_ptr;
  logic [5:0] walk_rd_idx0, walk_rd_idx1;
  logic       walk_rd_need_to_wb0, walk_rd_need_to_wb1;
  logic [5:0] walk_rd_prd0, walk_rd_prd1;
  logic [1:0] rob_state;
  logic       walking_valid0, walking_valid1;
  logic [5:0] walking_old_prd0, walking_old_prd1;
  logic       rename_stall;
  logic       walk_done;

  logic       need_mem [64];
  logic [5:0] prd_mem  [64];

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  typedef struct {
    int unsigned st, v0, v1, p0, p1, i0, i1, done;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  assign walk_rd_need_to_wb0 = need_mem[walk_rd_idx0];
  assign walk_rd_need_to_wb1 = need_mem[walk_rd_idx1];
  assign walk_rd_prd0        = prd_mem[walk_rd_idx0];
  assign walk_rd_prd1        = prd_mem[walk_rd_idx1];

  rob_walk_ctrl #(
    .ROB_DEPTH  (64),
    .PREG_WIDTH (6)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .flush_valid         (flush_valid),
    .flush_robidx        (flush_robidx),
    .rob_tail_ptr        (rob_tail_ptr),
    .walk_rd_idx0        (walk_rd_idx0),
    .walk_rd_idx1        (walk_rd_idx1),
    .walk_rd_need_to_wb0 (walk_rd_need_to_wb0),
    .walk_rd_need_to_wb1 (walk_rd_need_to_wb1),
    .walk_rd_prd0        (walk_rd_prd0),
    .walk_rd_prd1        (walk_rd_prd1),
    .rob_state           (rob_state),
    .walking_valid0      (walking_valid0),
    .walking_valid1      (walking_valid1),
    .walking_old_prd0    (walking_old_prd0),
    .walking_old_prd1    (walking_old_prd1),
    .rename_stall        (rename_stall),
    .walk_done           (walk_done)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t e_idle(input int unsigned done);
    exp_t e;
    e = '{0, 0, 0, 0, 0, 0, 0, 0};
    e.done = done;
    return e;
  endfunction

  function automatic exp_t e_rb();
    exp_t e;
    e = '{1, 0, 0, 0, 0, 0, 0, 0};
    return e;
  endfunction

  // Expected WALK-cycle outputs with the walk pointer at ptr and end at endp.
  function automatic exp_t e_walk(input int unsigned ptr, input int unsigned endp);
    exp_t        e;
    int unsigned rem;
    rem    = (endp - ptr) & 127;
    e.st   = 2;
    e.i0   = ptr % 64;
    e.i1   = (ptr + 1) % 64;
    e.v0   = (rem >= 1 && need_mem[e.i0]) ? 1 : 0;
    e.v1   = (rem >= 2 && need_mem[e.i1]) ? 1 : 0;
    e.p0   = prd_mem[e.i0];
    e.p1   = prd_mem[e.i1];
    e.done = 0;
    return e;
  endfunction

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Full recovery: flush cycle, ROLLBACK, the walk, then the walk_done cycle.
  task automatic run_walk(input int unsigned idx, input int unsigned tail);
    int unsigned ptr, endp, rem;
    int          guard;
    flush_valid  = 1'b1;
    flush_robidx = 7'(idx);
    rob_tail_ptr = 7'(tail);
    step(e_idle(0));
    flush_valid  = 1'b0;
    rob_tail_ptr = 7'($urandom);  // must not disturb the captured end pointer
    step(e_rb());
    ptr   = (idx + 1) & 127;
    endp  = tail & 127;
    guard = 0;
    while (ptr != endp && guard < 200) begin
      step(e_walk(ptr, endp));
      rem = (endp - ptr) & 127;
      ptr = (ptr + ((rem >= 2) ? 2 : rem)) & 127;
      guard++;
    end
    step(e_idle(1));
    step(e_idle(0));
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_txn++;
      $display("txn %0d st=%0d v=%0d%0d prd=%0d,%0d idx=%0d,%0d done=%0d",
               n_txn, rob_state, walking_valid0, walking_valid1, walking_old_prd0,
               walking_old_prd1, walk_rd_idx0, walk_rd_idx1, walk_done);
      chk("state", rob_state, e.st);
      chk("stall", rename_stall, (e.st != 0) ? 1 : 0);
      chk("valid0", walking_valid0, e.v0);
      chk("valid1", walking_valid1, e.v1);
      chk("prd0", walking_old_prd0, e.p0);
      chk("prd1", walking_old_prd1, e.p1);
      chk("idx0", walk_rd_idx0, e.i0);
      chk("idx1", walk_rd_idx1, e.i1);
      chk("done", walk_done, e.done);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, rob_state, 0);
    chk({tag, "_stall"}, rename_stall, 0);
    chk({tag, "_valid0"}, walking_valid0, 0);
    chk({tag, "_valid1"}, walking_valid1, 0);
    chk({tag, "_prd0"}, walking_old_prd0, 0);
    chk({tag, "_prd1"}, walking_old_prd1, 0);
    chk({tag, "_idx0"}, walk_rd_idx0, 0);
    chk({tag, "_idx1"}, walk_rd_idx1, 0);
    chk({tag, "_done"}, walk_done, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      need_mem[i] = 1'b1;
      prd_mem[i]  = 6'((i * 5 + 3) & 63);
    end
    reset_n      = 1'b0;
    flush_valid  = 1'b0;
    flush_robidx = '0;
    rob_tail_ptr = '0;
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Basic 3-entry walk returning prds 40, 41, 42.
    prd_mem[6] = 6'd40;
    prd_mem[7] = 6'd41;
    prd_mem[8] = 6'd42;
    run_walk(5, 9);

    // Nothing younger than the flushing entry.
    run_walk(9, 10);

    // Walk across the ROB wrap point: indices 63,0 then 1,2.
    run_walk(62, 67);

    // Sparse need_to_wb pattern; pointer still steps by two.
    need_mem[20] = 1'b1;
    need_mem[21] = 1'b0;
    need_mem[22] = 1'b1;
    need_mem[23] = 1'b0;
    run_walk(19, 24);

    // Full ROB: 64 entries in 32 WALK cycles.
    run_walk(30, 95);

    // Random short walks with random need_to_wb.
    for (int r = 0; r < 4; r++) begin
      int unsigned idx, len;
      for (int i = 0; i < 64; i++) need_mem[i] = 1'($urandom);
      idx = $urandom_range(0, 127);
      len = $urandom_range(0, 9);
      run_walk(idx, idx + 1 + len);
    end

    // Mid-walk re-flush: younger index ignored, older index restarts at 4.
    for (int i = 0; i < 64; i++) need_mem[i] = 1'b1;
    flush_valid  = 1'b1;
    flush_robidx = 7'd9;
    rob_tail_ptr = 7'd30;
    step(e_idle(0));
    flush_valid = 1'b0;
    step(e_rb());
    flush_valid  = 1'b1;
    flush_robidx = 7'd20;
    rob_tail_ptr = 7'd8;
    step(e_walk(10, 30));
    flush_robidx = 7'd3;
    step(e_walk(12, 30));
    flush_valid  = 1'b0;
    rob_tail_ptr = 7'd50;
    step(e_rb());
    step(e_walk(4, 8));
    step(e_walk(6, 8));
    step(e_idle(1));
    step(e_idle(0));

    // Reset in the middle of a walk.
    flush_valid  = 1'b1;
    flush_robidx = 7'd9;
    rob_tail_ptr = 7'd30;
    step(e_idle(0));
    flush_valid = 1'b0;
    step(e_rb());
    step(e_walk(10, 30));
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) step(e_idle(0));

    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
